// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmit path
// between several requesters. It latches the winning frame, fires a single
// trigger into the UART core, then blocks new grants for a guard interval so
// the UART output FIFO can drain before the next frame is launched.

module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_BYTES = 18,
    parameter int DBITS       = 8,
    parameter int GAP_CYCLES  = 1_935_360
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ*FRAME_BYTES*DBITS-1:0]   req_frame,
    output logic [NUM_REQ-1:0]                     ack,
    output logic [NUM_REQ-1:0]                     grant,
    output logic [FRAME_BYTES*DBITS-1:0]           tx_frame,
    output logic                                   tx_trigger,
    output logic                                   busy
);

    localparam int FW = FRAME_BYTES * DBITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FIRE = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]         state;
    logic [2:0]         ptr;
    logic [2:0]         winner;
    logic [31:0]        cnt;

    logic               pick_valid;
    logic [2:0]         pick_idx;
    logic [3:0]         scan_sum;
    logic [FW-1:0]      pick_frame;
    logic [NUM_REQ-1:0] pick_onehot;

    // Pick the first requester at or after ptr (wrapping), and its frame slice
    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = 3'd0;
        scan_sum    = 4'd0;
        pick_frame  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = 4'(ptr) + 4'(k);
            if (scan_sum >= 4'(NUM_REQ)) begin
                scan_sum = scan_sum - 4'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!pick_valid && scan_sum == 4'(j) && req[j]) begin
                    pick_valid = 1'b1;
                    pick_idx   = 3'(j);
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_idx == 3'(j)) begin
                pick_frame = req_frame[j*FW +: FW];
            end
        end
        pick_onehot = NUM_REQ'(1) << pick_idx;
    end

    // Transaction sequencing: grant in IDLE, trigger in FIRE, guard interval in GAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 3'd0;
            winner     <= 3'd0;
            cnt        <= 32'd0;
            ack        <= '0;
            grant      <= '0;
            tx_frame   <= '0;
            tx_trigger <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        tx_frame <= pick_frame;
                        ack      <= pick_onehot;
                        grant    <= pick_onehot;
                        winner   <= pick_idx;
                        state    <= FIRE;
                    end
                end
                FIRE: begin
                    tx_trigger <= 1'b1;
                    ack        <= '0;
                    cnt        <= 32'(GAP_CYCLES - 1);
                    state      <= GAP;
                end
                GAP: begin
                    tx_trigger <= 1'b0;
                    if (cnt == 32'd0) begin
                        state <= IDLE;
                        grant <= '0;
                        if (winner == 3'(NUM_REQ - 1)) begin
                            ptr <= 3'd0;
                        end else begin
                            ptr <= winner + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ack        <= '0;
                    grant      <= '0;
                    tx_trigger <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with four requesters and a short
// guard interval so whole transactions fit in a handful of cycles.

module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int FRAME_BYTES = 18;
    localparam int DBITS       = 8;
    localparam int GAP_CYCLES  = 4;
    localparam int FW          = FRAME_BYTES * DBITS;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*FW-1:0]  req_frame;
    logic [NUM_REQ-1:0]     ack;
    logic [NUM_REQ-1:0]     grant;
    logic [FW-1:0]          tx_frame;
    logic                   tx_trigger;
    logic                   busy;

    logic [FW-1:0] frame0;
    logic [FW-1:0] frame1;
    logic [FW-1:0] frame2;
    logic [FW-1:0] frame3;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int last_trig  = -1;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .FRAME_BYTES (FRAME_BYTES),
        .DBITS       (DBITS),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_frame  (req_frame),
        .ack        (ack),
        .grant      (grant),
        .tx_frame   (tx_frame),
        .tx_trigger (tx_trigger),
        .busy       (busy)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    assign req_frame = {frame3, frame2, frame1, frame0};

    function automatic logic [FW-1:0] frameOf(input int idx);
        case (idx)
            0:       return frame0;
            1:       return frame1;
            2:       return frame2;
            default: return frame3;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] value);
        req = value;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic runTransaction(input string tag, input int idx,
                                  input logic [NUM_REQ-1:0] late_mask,
                                  input bit check_spacing);
        int waited;
        logic [NUM_REQ-1:0] oh;
        oh     = NUM_REQ'(1) << idx;
        waited = 0;
        while (ack == '0 && waited < 20) begin
            nextCycle();
            waited++;
        end
        checkOutput({tag, "_ack_latency"}, FW'(waited), FW'(1));
        checkOutput({tag, "_ack"}, FW'(ack), FW'(oh));
        checkOutput({tag, "_grant_at_ack"}, FW'(grant), FW'(oh));
        checkOutput({tag, "_trig_at_ack"}, FW'(tx_trigger), FW'(0));
        checkOutput({tag, "_busy_at_ack"}, FW'(busy), FW'(1));
        req = req & ~oh;
        nextCycle();
        checkOutput({tag, "_trigger"}, FW'(tx_trigger), FW'(1));
        checkOutput({tag, "_ack_cleared"}, FW'(ack), FW'(0));
        checkOutput({tag, "_tx_frame"}, tx_frame, frameOf(idx));
        if (check_spacing && last_trig >= 0) begin
            checkOutput({tag, "_trig_spacing"}, FW'(cycle - last_trig), FW'(GAP_CYCLES + 2));
        end
        last_trig = cycle;
        for (int i = 0; i < GAP_CYCLES - 1; i++) begin
            nextCycle();
            if (i == 0) begin
                req = req | late_mask;
            end
            checkOutput({tag, "_gap_trig"}, FW'(tx_trigger), FW'(0));
            checkOutput({tag, "_gap_ack"}, FW'(ack), FW'(0));
            checkOutput({tag, "_gap_grant"}, FW'(grant), FW'(oh));
        end
        nextCycle();
        checkOutput({tag, "_grant_end"}, FW'(grant), FW'(0));
        checkOutput({tag, "_busy_end"}, FW'(busy), FW'(0));
        checkOutput({tag, "_trig_end"}, FW'(tx_trigger), FW'(0));
    endtask

    // Directed test sequence
    initial begin
        reset  = 1'b1;
        req    = '0;
        frame0 = "welcome to devmode";
        frame1 = "requester number 1";
        frame2 = "requester number 2";
        frame3 = "requester number 3";

        nextCycle();
        checkOutput("rst_ack", FW'(ack), FW'(0));
        checkOutput("rst_grant", FW'(grant), FW'(0));
        checkOutput("rst_busy", FW'(busy), FW'(0));
        nextCycle();
        reset = 1'b0;

        $display("[TB] test 1: idle after reset");
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            checkOutput("idle_trig", FW'(tx_trigger), FW'(0));
            checkOutput("idle_busy", FW'(busy), FW'(0));
        end
        checkOutput("idle_ack", FW'(ack), FW'(0));
        checkOutput("idle_grant", FW'(grant), FW'(0));
        checkOutput("idle_frame", tx_frame, FW'(0));

        $display("[TB] test 2: single request");
        applyStimulus(4'b0001);
        runTransaction("single", 0, 4'b0000, 1'b0);

        $display("[TB] test 3: simultaneous requests");
        pulseReset();
        last_trig = -1;
        applyStimulus(4'b1111);
        runTransaction("all_r0", 0, 4'b0000, 1'b1);
        runTransaction("all_r1", 1, 4'b0000, 1'b1);
        runTransaction("all_r2", 2, 4'b0000, 1'b1);
        runTransaction("all_r3", 3, 4'b0000, 1'b1);
        checkOutput("all_req_drained", FW'(req), FW'(0));

        $display("[TB] test 4: wrap and fairness");
        applyStimulus(4'b1000);
        runTransaction("wrap_r3", 3, 4'b0000, 1'b0);
        applyStimulus(4'b1001);
        runTransaction("wrap_r0", 0, 4'b0000, 1'b0);
        runTransaction("wrap_r3b", 3, 4'b0000, 1'b0);

        $display("[TB] test 5: late-arriving request");
        applyStimulus(4'b0010);
        runTransaction("late_r1", 1, 4'b0100, 1'b0);
        runTransaction("late_r2", 2, 4'b0000, 1'b0);

        $display("[TB] test 6: reset mid-operation");
        applyStimulus(4'b0010);
        nextCycle();
        checkOutput("mid_ack", FW'(ack), FW'(4'b0010));
        applyStimulus(4'b0000);
        nextCycle();
        checkOutput("mid_trigger", FW'(tx_trigger), FW'(1));
        nextCycle();
        nextCycle();
        checkOutput("mid_gap_grant", FW'(grant), FW'(4'b0010));
        reset = 1'b1;
        #1;
        checkOutput("async_grant", FW'(grant), FW'(0));
        checkOutput("async_busy", FW'(busy), FW'(0));
        checkOutput("async_frame", tx_frame, FW'(0));
        checkOutput("async_trig", FW'(tx_trigger), FW'(0));
        checkOutput("async_ack", FW'(ack), FW'(0));
        nextCycle();
        checkOutput("held_trig", FW'(tx_trigger), FW'(0));
        reset = 1'b0;
        applyStimulus(4'b0010);
        runTransaction("after_rst_r1", 1, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
